vnlp_scan: RTL and testbench

Parametrised successor of the VNLP engine. It scans a window of a word-addressed data memory and splits it into records, where a record is a maximal run of non-zero words ended by a zero word or by the end of the window. It reports a selected record statistic (max-sum, longest, or total), the matching length, and the record count. The block sits in the datapath beside the data memory and drives that memory's read port while busy.

---
 rtl/vnlp_pkg.sv | 28 ++
 rtl/vnlp_rec_sel.sv | 83 ++++++++
 rtl/vnlp_scan.sv | 127 ++++++++++++
 tb/tb_vnlp_scan.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vnlp_pkg.sv
// Shared types and helpers for the VNLP window scanner: FSM states, mode codes
// and a width-generic saturating adder.
package vnlp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EVAL  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_MAXSUM  = 2'd0;
  localparam logic [1:0] MODE_LONGEST = 2'd1;
  localparam logic [1:0] MODE_TOTAL   = 2'd2;

  // Returns {saturated, sum}; the sum is clamped to the all-ones value of w bits (w <= 63).
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (s > lim) sat_add = {1'b1, lim[63:0]};
    else         sat_add = {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/vnlp_rec_sel.sv
// Run accumulators and best-record selection for the VNLP scanner. One word is
// absorbed per valid cycle; close ends a pending record at the window end.
module vnlp_rec_sel
  import vnlp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 28,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [DATA_W-1:0] word,
  input  logic              valid,
  input  logic              close,
  input  logic [1:0]        mode,
  output logic [ACC_W-1:0]  best_sum,
  output logic [LEN_W-1:0]  best_len,
  output logic [ACC_W-1:0]  total,
  output logic [LEN_W-1:0]  nz_count,
  output logic [LEN_W-1:0]  rec_count,
  output logic              sat
);

  logic [ACC_W-1:0] run_sum;
  logic [LEN_W-1:0] run_len;
  logic [64:0]      rs_add, tot_add, rl_add, nz_add, rc_add;
  logic             nz_word, do_close, better;
  logic             unused_bits;

  assign rs_add  = sat_add(64'(run_sum), 64'(word), ACC_W);
  assign tot_add = sat_add(64'(total), 64'(word), ACC_W);
  assign rl_add  = sat_add(64'(run_len), 64'd1, LEN_W);
  assign nz_add  = sat_add(64'(nz_count), 64'd1, LEN_W);
  assign rc_add  = sat_add(64'(rec_count), 64'd1, LEN_W);
  assign unused_bits = ^{rs_add[63:ACC_W], tot_add[63:ACC_W], rl_add[64:LEN_W],
                         nz_add[64:LEN_W], rc_add[64:LEN_W]};

  assign nz_word  = valid && (word != '0);
  assign do_close = (close || (valid && word == '0)) && (run_len != '0);
  // Strict comparison keeps the earliest record on ties.
  assign better   = (mode == MODE_LONGEST) ? (run_len > best_len) : (run_sum > best_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sum   <= '0;
      run_len   <= '0;
      best_sum  <= '0;
      best_len  <= '0;
      total     <= '0;
      nz_count  <= '0;
      rec_count <= '0;
      sat       <= 1'b0;
    end else if (clear) begin
      run_sum   <= '0;
      run_len   <= '0;
      best_sum  <= '0;
      best_len  <= '0;
      total     <= '0;
      nz_count  <= '0;
      rec_count <= '0;
      sat       <= 1'b0;
    end else begin
      if (nz_word) begin
        run_sum  <= rs_add[ACC_W-1:0];
        run_len  <= rl_add[LEN_W-1:0];
        total    <= tot_add[ACC_W-1:0];
        nz_count <= nz_add[LEN_W-1:0];
        if (rs_add[64] || tot_add[64]) sat <= 1'b1;
      end
      if (do_close) begin
        rec_count <= rc_add[LEN_W-1:0];
        if (better) begin
          best_sum <= run_sum;
          best_len <= run_len;
        end
        run_sum <= '0;
        run_len <= '0;
      end
    end
  end

endmodule

// File: rtl/vnlp_scan.sv
// VNLP window scanner: walks Limit words from Base (wrapping), splits them into
// zero-terminated records and reports the statistic selected by Mode.
module vnlp_scan
  import vnlp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int ACC_W  = 28,
  parameter int LEN_W  = 9
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base,
  input  logic [ADDR_W:0]   Limit,
  input  logic [1:0]        Mode,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Rd,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic [ACC_W-1:0]  Result,
  output logic [LEN_W-1:0]  Len,
  output logic [LEN_W-1:0]  Rec_Count,
  output logic              Sat,
  output logic              Busy,
  output logic              Done,
  output state_t            Dbg_State
);

  // Protocol: Start is a one-cycle request honoured only in IDLE/DONE; Busy covers
  // the whole scan; Done is a level held until the next accepted Start. Mem_Rd is
  // high only in FETCH and Mem_Data is consumed in the following (EVAL) cycle.
  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   limit_q, idx, idx_next;
  logic [1:0]        mode_q, mode_n;
  logic              start_ok;
  logic [ACC_W-1:0]  best_sum, total;
  logic [LEN_W-1:0]  best_len, nz_count, rec_count;

  assign start_ok  = Start && (state == ST_IDLE || state == ST_DONE);
  assign mode_n    = (Mode == 2'd3) ? MODE_MAXSUM : Mode;
  assign idx_next  = idx + 1'b1;
  assign Dbg_State = state;

  vnlp_rec_sel #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) u_rec_sel (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .clear     (start_ok),
    .word      (Mem_Data),
    .valid     (state == ST_EVAL),
    .close     (state == ST_FLUSH),
    .mode      (mode_q),
    .best_sum  (best_sum),
    .best_len  (best_len),
    .total     (total),
    .nz_count  (nz_count),
    .rec_count (rec_count),
    .sat       (Sat)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      limit_q   <= '0;
      mode_q    <= MODE_MAXSUM;
      idx       <= '0;
      Mem_Addr  <= '0;
      Mem_Rd    <= 1'b0;
      Result    <= '0;
      Len       <= '0;
      Rec_Count <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            base_q    <= Base;
            limit_q   <= Limit;
            mode_q    <= mode_n;
            idx       <= '0;
            Rec_Count <= '0;
            Done      <= 1'b0;
            Busy      <= 1'b1;
            if (Limit == '0) begin
              state <= ST_FLUSH;
            end else begin
              state    <= ST_FETCH;
              Mem_Rd   <= 1'b1;
              Mem_Addr <= Base;
            end
          end else if (state == ST_DONE && !Done) begin
            // First DONE cycle: the record closed in FLUSH is now visible.
            if (mode_q == MODE_TOTAL) begin
              Result <= total;
              Len    <= nz_count;
            end else begin
              Result <= best_sum;
              Len    <= best_len;
            end
            Rec_Count <= rec_count;
            Done      <= 1'b1;
            Busy      <= 1'b0;
          end
        end
        ST_FETCH: begin
          Mem_Rd <= 1'b0;
          state  <= ST_EVAL;
        end
        ST_EVAL: begin
          idx <= idx_next;
          if (idx_next == limit_q) begin
            state <= ST_FLUSH;
          end else begin
            state    <= ST_FETCH;
            Mem_Rd   <= 1'b1;
            Mem_Addr <= base_q + idx_next[ADDR_W-1:0];
          end
        end
        ST_FLUSH: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vnlp_scan.sv
// Self-checking bench for vnlp_scan: directed scenarios plus random windows,
// checked against a record-list reference model for two accumulator widths.
module tb_vnlp_scan;
  import vnlp_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 9;
  localparam int ACC_A  = 28;
  localparam int ACC_B  = 10;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic [ADDR_W-1:0] Base = '0;
  logic [ADDR_W:0]   Limit = '0;
  logic [1:0]        Mode = '0;

  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              a_rd, b_rd;
  logic [DATA_W-1:0] a_data = '0, b_data = '0;
  logic [ACC_A-1:0]  a_result;
  logic [ACC_B-1:0]  b_result;
  logic [LEN_W-1:0]  a_len, b_len, a_cnt, b_cnt;
  logic              a_sat, b_sat, a_busy, b_busy, a_done, b_done;
  state_t            a_state, b_state;

  logic [DATA_W-1:0] mem [512];
  logic [ADDR_W-1:0] addr_q[$];
  int                rd_cnt = 0;
  int                n_cmp = 0;
  int                n_err = 0;

  vnlp_scan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_A), .LEN_W(LEN_W)) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Base(Base), .Limit(Limit), .Mode(Mode),
    .Mem_Addr(a_addr), .Mem_Rd(a_rd), .Mem_Data(a_data), .Result(a_result), .Len(a_len),
    .Rec_Count(a_cnt), .Sat(a_sat), .Busy(a_busy), .Done(a_done), .Dbg_State(a_state)
  );

  vnlp_scan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_B), .LEN_W(LEN_W)) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Base(Base), .Limit(Limit), .Mode(Mode),
    .Mem_Addr(b_addr), .Mem_Rd(b_rd), .Mem_Data(b_data), .Result(b_result), .Len(b_len),
    .Rec_Count(b_cnt), .Sat(b_sat), .Busy(b_busy), .Done(b_done), .Dbg_State(b_state)
  );

  // Clock / reset block and the one-cycle read latency memory model.
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (a_rd) begin
      a_data <= mem[a_addr];
      addr_q.push_back(a_addr);
      rd_cnt <= rd_cnt + 1;
    end
    if (b_rd) b_data <= mem[b_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: list the records of the window, then pick by mode.
  function automatic void ref_scan(input int acc_w, input int base, input int limit,
                                   input int mode, output longint res, output longint len,
                                   output longint cnt, output longint sat);
    longint rs[$];
    longint rl[$];
    longint cur = 0, cl = 0, tot = 0, nz = 0, mx, key, best_key;
    int     bi;
    mx = (longint'(1) << acc_w) - 1;
    for (int i = 0; i < limit; i++) begin
      int w = int'(mem[(base + i) % 512]);
      if (w != 0) begin
        cur += w; cl++; tot += w; nz++;
      end else if (cl > 0) begin
        rs.push_back(cur); rl.push_back(cl); cur = 0; cl = 0;
      end
    end
    if (cl > 0) begin
      rs.push_back(cur); rl.push_back(cl);
    end
    sat = (tot > mx) ? 1 : 0;
    cnt = (rs.size() > 511) ? 511 : rs.size();
    if (mode == 3) mode = 0;
    res = 0; len = 0;
    if (mode == 2) begin
      res = (tot > mx) ? mx : tot;
      len = (nz > 511) ? 511 : nz;
    end else begin
      bi = -1; best_key = -1;
      for (int r = 0; r < rs.size(); r++) begin
        key = (mode == 0) ? ((rs[r] > mx) ? mx : rs[r]) : ((rl[r] > 511) ? 511 : rl[r]);
        if (key > best_key) begin
          best_key = key; bi = r;
        end
      end
      if (bi >= 0) begin
        res = (rs[bi] > mx) ? mx : rs[bi];
        len = (rl[bi] > 511) ? 511 : rl[bi];
      end
    end
  endfunction

  // Driver: issue one scan, optionally re-pulse Start mid-scan, wait for Done.
  task automatic run_scan(input string tag, input int base, input int limit, input int mode,
                          input int glitch_at);
    int     cycles;
    int     budget;
    longint res, len, cnt, sat;
    @(negedge Clk);
    Base = ADDR_W'(base); Limit = (ADDR_W+1)'(limit); Mode = 2'(mode);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    check({tag, "_busy"}, 64'(a_busy), 64'd1);
    cycles = 0;
    budget = 2 * limit + 10;
    while (cycles < budget) begin
      @(posedge Clk);
      cycles++;
      #1 Start = 1'b0;
      if (a_done) break;
      if (cycles == glitch_at) begin
        Base = 9'd3; Limit = 10'd0; Mode = 2'd2; Start = 1'b1;
      end
    end
    check({tag, "_latency"}, 64'(cycles), 64'(2 * limit + 2));
    check({tag, "_done_b"}, 64'(b_done), 64'd1);
    check({tag, "_busy_end"}, 64'(a_busy), 64'd0);
    ref_scan(ACC_A, base, limit, mode, res, len, cnt, sat);
    check({tag, "_res_a"}, 64'(a_result), 64'(res));
    check({tag, "_len_a"}, 64'(a_len), 64'(len));
    check({tag, "_cnt_a"}, 64'(a_cnt), 64'(cnt));
    check({tag, "_sat_a"}, 64'(a_sat), 64'(sat));
    ref_scan(ACC_B, base, limit, mode, res, len, cnt, sat);
    check({tag, "_res_b"}, 64'(b_result), 64'(res));
    check({tag, "_len_b"}, 64'(b_len), 64'(len));
    check({tag, "_cnt_b"}, 64'(b_cnt), 64'(cnt));
    check({tag, "_sat_b"}, 64'(b_sat), 64'(sat));
  endtask

  task automatic load_std();
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[0] = 8'd30; mem[1] = 8'd35; mem[2] = 8'd34; mem[3] = 8'd40;
    foreach (mem[i]) begin
      if ((i >= 5 && i <= 8) || (i >= 11 && i <= 14) || (i >= 17 && i <= 20) ||
          (i >= 22 && i <= 25) || (i >= 39 && i <= 42) || (i >= 44 && i <= 47) ||
          (i >= 49 && i <= 52)) begin
        case ((i - 1) % 4)
          0: mem[i] = 8'd40;
          1: mem[i] = 8'd45;
          2: mem[i] = 8'd50;
          default: mem[i] = 8'd40;
        endcase
      end
    end
    for (int i = 28; i <= 31; i++) mem[i] = 8'd100;
    mem[34] = 8'd50; mem[35] = 8'd50; mem[36] = 8'd58;
  endtask

  initial begin
    int snap;
    load_std();
    #12;
    check("rst_result", 64'(a_result), 64'd0);
    check("rst_len", 64'(a_len), 64'd0);
    check("rst_cnt", 64'(a_cnt), 64'd0);
    check("rst_flags", 64'({a_sat, a_busy, a_done, a_rd}), 64'd0);
    check("rst_addr", 64'(a_addr), 64'd0);
    check("rst_state", 64'(a_state), 64'(ST_IDLE));
    @(negedge Clk);
    Reset_n = 1'b1;

    // Standard set in all modes, with constants alongside the model.
    run_scan("std_m0", 0, 64, 0, 0);
    check("std_m0_400", 64'(a_result), 64'd400);
    check("std_m0_len4", 64'(a_len), 64'd4);
    check("std_m0_cnt10", 64'(a_cnt), 64'd10);
    check("std_m0_nosat", 64'(a_sat), 64'd0);
    run_scan("std_m1", 0, 64, 1, 0);
    check("std_m1_139", 64'(a_result), 64'd139);
    check("std_m1_len4", 64'(a_len), 64'd4);
    run_scan("std_m2", 0, 64, 2, 0);
    check("std_m2_1922", 64'(a_result), 64'd1922);
    check("std_m2_len39", 64'(a_len), 64'd39);
    run_scan("std_m3", 0, 64, 3, 0);
    check("std_m3_as_m0", 64'(a_result), 64'd400);

    snap = rd_cnt;
    run_scan("lim0", 0, 0, 0, 0);
    check("lim0_no_rd", 64'(rd_cnt - snap), 64'd0);
    check("lim0_cnt", 64'(a_cnt), 64'd0);

    mem[510] = 8'd7; mem[511] = 8'd8; mem[0] = 8'd9; mem[1] = 8'd0;
    snap = addr_q.size();
    run_scan("wrap", 510, 4, 0, 0);
    check("wrap_nrd", 64'(addr_q.size() - snap), 64'd4);
    check("wrap_a0", 64'(addr_q[snap]), 64'd510);
    check("wrap_a1", 64'(addr_q[snap + 1]), 64'd511);
    check("wrap_a2", 64'(addr_q[snap + 2]), 64'd0);
    check("wrap_a3", 64'(addr_q[snap + 3]), 64'd1);
    check("wrap_24", 64'(a_result), 64'd24);
    check("wrap_len3", 64'(a_len), 64'd3);

    load_std();
    for (int i = 100; i < 105; i++) mem[i] = 8'd255;
    run_scan("satur", 100, 6, 0, 0);
    check("satur_b_1023", 64'(b_result), 64'd1023);
    check("satur_b_len5", 64'(b_len), 64'd5);
    check("satur_b_sat", 64'(b_sat), 64'd1);

    run_scan("edge", 28, 4, 0, 0);
    check("edge_400", 64'(a_result), 64'd400);
    check("edge_cnt1", 64'(a_cnt), 64'd1);

    run_scan("glitch", 0, 64, 0, 17);
    check("glitch_400", 64'(a_result), 64'd400);

    // Asynchronous reset in the middle of a scan.
    @(negedge Clk);
    Base = '0; Limit = 10'd64; Mode = 2'd0; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (20) @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_result", 64'(a_result), 64'd0);
    check("mid_rst_flags", 64'({a_busy, a_done, a_rd, a_sat}), 64'd0);
    check("mid_rst_addr", 64'(a_addr), 64'd0);
    check("mid_rst_cnt", 64'(a_cnt), 64'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    run_scan("post_rst", 0, 64, 0, 0);
    check("post_rst_400", 64'(a_result), 64'd400);

    // Random windows over random memory.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 512; i++)
        mem[i] = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_scan("rnd", int'($urandom_range(0, 511)), int'($urandom_range(0, 100)),
               int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
